// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the instruction loader and the control unit.
//   - Opcode constants for every instruction the control unit decodes
//   - HALT word that ends an instruction load
//   - Loader FSM state type and loader error codes
//   - is_legal_opcode(): true for opcodes the control unit decodes
package mips_pkg;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone,
    StError
  } loader_state_e;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrOpcode   = 2'b01;
  localparam logic [1:0] ErrOverflow = 2'b10;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpJ, OpAddi, OpSlti: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream big-endian into NBITS-wide words.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : drop any partial word (start of a new load)
//   i_byte_valid     : a byte transfers this cycle
//   i_byte_data      : the byte
//   o_word           : word including the current byte (complete when o_word_valid)
//   o_word_valid     : current byte completes a word
module byte_assembler #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned BYTE_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_byte_valid,
  input  logic [BYTE_BITS-1:0] i_byte_data,
  output logic [NBITS-1:0]     o_word,
  output logic                 o_word_valid
);

  localparam int unsigned NBytes = NBITS / BYTE_BITS;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [NBITS-1:0] word_q;
  logic [IdxW-1:0]  idx_q;
  logic             last_byte;

  // Shift left so the first byte of a word ends up in the top byte lane.
  always_comb begin
    o_word       = {word_q[NBITS-BYTE_BITS-1:0], i_byte_data};
    last_byte    = (idx_q == IdxW'(NBytes - 1));
    o_word_valid = i_byte_valid & last_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_byte_valid) begin
      word_q <= o_word;
      idx_q  <= last_byte ? '0 : idx_q + IdxW'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads MIPS instruction words from a byte stream into instruction memory.
// Words are written at sequential addresses from 0 until the HALT word.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_start                : pulse, begins a load at address 0
//   i_rx_data/i_rx_valid   : incoming byte stream; o_rx_ready accepts a byte
//   o_mem_addr/o_mem_data  : write address and word, held between writes
//   o_mem_we               : one-cycle write strobe
//   o_busy/o_done          : load in progress / load finished with HALT
//   o_err_code             : 00 none, 01 illegal opcode, 10 memory overflow
//   o_count                : words written in the current load
// Build option: define OPCODE_CHECK_EN to reject words the control unit cannot decode.
module instruction_loader
  import mips_pkg::*;
#(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned BYTE_BITS = 8,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BYTE_BITS-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [NBITS-1:0]     o_mem_data,
  output logic                 o_mem_we,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_err_code,
  output logic [ADDR_BITS:0]   o_count
);

  loader_state_e        state_q;
  logic [NBITS-1:0]     word_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [NBITS-1:0]     mem_data_q;
  logic                 mem_we_q;
  logic                 rx_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [1:0]           err_q;
  logic [ADDR_BITS:0]   count_q;

  logic             accept;
  logic             asm_clear;
  logic [NBITS-1:0] asm_word;
  logic             asm_valid;
  logic             asm_halt;
  logic             asm_legal;
  logic             word_halt;
  logic             word_legal;

  always_comb begin
    accept    = i_rx_valid & rx_ready_q;
    asm_clear = i_start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StError));
    asm_halt  = (asm_word == NBITS'(HaltWord));
    word_halt = (word_q == NBITS'(HaltWord));
`ifdef OPCODE_CHECK_EN
    asm_legal  = is_legal_opcode(asm_word[NBITS-1 -: 6]);
    word_legal = is_legal_opcode(word_q[NBITS-1 -: 6]);
`else
    asm_legal  = 1'b1;
    word_legal = 1'b1;
`endif
  end

  byte_assembler #(
    .NBITS    (NBITS),
    .BYTE_BITS(BYTE_BITS)
  ) u_byte_assembler (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (asm_clear),
    .i_byte_valid(accept),
    .i_byte_data (i_rx_data),
    .o_word      (asm_word),
    .o_word_valid(asm_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ErrNone;
      count_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (i_start) begin
            state_q    <= StRecv;
            addr_q     <= '0;
            count_q    <= '0;
            err_q      <= ErrNone;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            rx_ready_q <= 1'b1;
          end
        end
        StRecv: begin
          if (asm_valid) begin
            state_q    <= StWrite;
            word_q     <= asm_word;
            rx_ready_q <= 1'b0;
            // Strobe is registered, so the write decision is made as the word completes.
            if (asm_halt || asm_legal) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= addr_q;
              mem_data_q <= asm_word;
              count_q    <= count_q + (ADDR_BITS + 1)'(1);
            end
          end
        end
        StWrite: begin
          if (word_halt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!word_legal) begin
            state_q <= StError;
            busy_q  <= 1'b0;
            err_q   <= ErrOpcode;
          end else if (&addr_q) begin
            state_q <= StError;
            busy_q  <= 1'b0;
            err_q   <= ErrOverflow;
          end else begin
            state_q    <= StRecv;
            addr_q     <= addr_q + ADDR_BITS'(1);
            rx_ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rx_ready = rx_ready_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_we   = mem_we_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err_code = err_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  addr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default memory depth
  logic        a_reset = 1'b0, a_start = 1'b0, a_valid = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_ready, a_we, a_busy, a_done;
  logic [7:0]  a_addr;
  logic [31:0] a_mdata;
  logic [1:0]  a_err;
  logic [8:0]  a_count;

  // DUT B: four-word memory for overflow
  logic        b_reset = 1'b0, b_start = 1'b0, b_valid = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_we, b_busy, b_done;
  logic [1:0]  b_addr;
  logic [31:0] b_mdata;
  logic [1:0]  b_err;
  logic [2:0]  b_count;

  instruction_loader #(.NBITS(32), .BYTE_BITS(8), .ADDR_BITS(8)) u_dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_start(a_start), .i_rx_data(a_data),
    .i_rx_valid(a_valid), .o_rx_ready(a_ready), .o_mem_addr(a_addr), .o_mem_data(a_mdata),
    .o_mem_we(a_we), .o_busy(a_busy), .o_done(a_done), .o_err_code(a_err), .o_count(a_count)
  );

  instruction_loader #(.NBITS(32), .BYTE_BITS(8), .ADDR_BITS(2)) u_dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_start(b_start), .i_rx_data(b_data),
    .i_rx_valid(b_valid), .o_rx_ready(b_ready), .o_mem_addr(b_addr), .o_mem_data(b_mdata),
    .o_mem_we(b_we), .o_busy(b_busy), .o_done(b_done), .o_err_code(b_err), .o_count(b_count)
  );

  int checks = 0;
  int errors = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: every write strobe must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (a_we === 1'b1) begin
      if (q_a.size() == 0) check("A unexpected write addr", {56'd0, a_addr}, 64'hFFFF);
      else begin
        wr_t e;
        e = q_a.pop_front();
        check("A write addr", {56'd0, a_addr}, {56'd0, e.addr});
        check("A write data", {32'd0, a_mdata}, {32'd0, e.data});
      end
    end
    if (b_we === 1'b1) begin
      if (q_b.size() == 0) check("B unexpected write addr", {62'd0, b_addr}, 64'hFFFF);
      else begin
        wr_t e;
        e = q_b.pop_front();
        check("B write addr", {62'd0, b_addr}, {56'd0, e.addr});
        check("B write data", {32'd0, b_mdata}, {32'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (sel) begin b_valid = 1'b1; b_data = b; end
    else begin a_valid = 1'b1; a_data = b; end
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((sel ? b_ready : a_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (sel) b_valid = 1'b0;
    else a_valid = 1'b0;
    if (!ok) check("byte accept timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(sel, w[k*8 +: 8]);
  endtask

  task automatic push_a(input logic [7:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    q_b.push_back(e);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    if (sel) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    a_reset = 1'b1;
    step();
    check("A reset rx_ready", {63'd0, a_ready}, 64'd0);
    check("A reset we", {63'd0, a_we}, 64'd0);
    check("A reset busy", {63'd0, a_busy}, 64'd0);
    check("A reset done", {63'd0, a_done}, 64'd0);
    check("A reset err", {62'd0, a_err}, 64'd0);
    check("A reset count", {55'd0, a_count}, 64'd0);
    check("A reset addr", {56'd0, a_addr}, 64'd0);
    check("A reset data", {32'd0, a_mdata}, 64'd0);
    @(negedge clk);
    a_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h2001_0005, 8'd0};
    vecs[1] = '{32'h8C22_0004, 8'd1};
    vecs[2] = '{32'hAC22_0008, 8'd2};
    vecs[3] = '{32'h1022_0003, 8'd3};
    vecs[4] = '{32'h0800_0010, 8'd4};
    vecs[5] = '{32'h2801_000A, 8'd5};
    vecs[6] = '{32'h0022_1820, 8'd6};
    vecs[7] = '{32'hFFFF_FFFF, 8'd7};

    // Basic load ending on HALT
    reset_a();
    pulse_start(1'b0);
    check("A busy after start", {63'd0, a_busy}, 64'd1);
    push_a(8'd0, 32'h2001_0005);
    send_word(1'b0, 32'h2001_0005);
    push_a(8'd1, 32'hFFFF_FFFF);
    send_word(1'b0, 32'hFFFF_FFFF);
    step();
    check("A done after halt", {63'd0, a_done}, 64'd1);
    check("A count after halt", {55'd0, a_count}, 64'd2);
    check("A err after halt", {62'd0, a_err}, 64'd0);
    check("A busy after halt", {63'd0, a_busy}, 64'd0);

    // Restart from DONE
    pulse_start(1'b0);
    check("A done cleared on restart", {63'd0, a_done}, 64'd0);
    check("A count cleared on restart", {55'd0, a_count}, 64'd0);
    push_a(8'd0, 32'hAC22_0008);
    send_word(1'b0, 32'hAC22_0008);
    step();
    check("A count after restart word", {55'd0, a_count}, 64'd1);
    push_a(8'd1, 32'hFFFF_FFFF);
    send_word(1'b0, 32'hFFFF_FFFF);
    step();
    check("A done after restart load", {63'd0, a_done}, 64'd1);

    // Table-driven load: every decoded opcode, then HALT
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      push_a(vecs[i].addr, vecs[i].word);
      send_word(1'b0, vecs[i].word);
    end
    step();
    check("A table done", {63'd0, a_done}, 64'd1);
    check("A table count", {55'd0, a_count}, 64'd8);

    // Gapped bytes and write-cycle latency
    pulse_start(1'b0);
    push_a(8'd0, 32'h8C22_0004);
    send_byte(1'b0, 8'h8C);
    repeat (3) @(posedge clk);
    send_byte(1'b0, 8'h22);
    repeat (3) @(posedge clk);
    send_byte(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    send_byte(1'b0, 8'h04);
    check("A we one cycle after last byte", {63'd0, a_we}, 64'd1);
    check("A rx_ready low in write cycle", {63'd0, a_ready}, 64'd0);
    check("A gapped data", {32'd0, a_mdata}, 64'h8C22_0004);
    step();
    check("A we single cycle", {63'd0, a_we}, 64'd0);
    check("A rx_ready back after write", {63'd0, a_ready}, 64'd1);
    check("A addr held after write", {56'd0, a_addr}, 64'd0);

    // Reset in the middle of a word
    reset_a();
    pulse_start(1'b0);
    send_byte(1'b0, 8'hAA);
    send_byte(1'b0, 8'hBB);
    reset_a();
    pulse_start(1'b0);
    push_a(8'd0, 32'h2001_0005);
    send_word(1'b0, 32'h2001_0005);
    step();
    check("A count after aborted load", {55'd0, a_count}, 64'd1);

    // Undecoded opcode
    reset_a();
    pulse_start(1'b0);
`ifdef OPCODE_CHECK_EN
    send_word(1'b0, 32'h3C01_0001);
    check("A illegal opcode no write", {63'd0, a_we}, 64'd0);
    step();
    check("A illegal opcode err", {62'd0, a_err}, 64'd1);
    check("A illegal opcode busy", {63'd0, a_busy}, 64'd0);
    check("A illegal opcode count", {55'd0, a_count}, 64'd0);
`else
    push_a(8'd0, 32'h3C01_0001);
    send_word(1'b0, 32'h3C01_0001);
    check("A unchecked opcode written", {63'd0, a_we}, 64'd1);
    step();
    check("A unchecked opcode err", {62'd0, a_err}, 64'd0);
    check("A unchecked opcode busy", {63'd0, a_busy}, 64'd1);
    check("A unchecked opcode count", {55'd0, a_count}, 64'd1);
`endif

    // Memory overflow on the small instance
    @(negedge clk);
    b_reset = 1'b1;
    step();
    check("B reset count", {61'd0, b_count}, 64'd0);
    @(negedge clk);
    b_reset = 1'b0;
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = 32'h2001_0001 + 32'(i);
      push_b(8'(i), w);
      send_word(1'b1, w);
    end
    step();
    check("B overflow err", {62'd0, b_err}, 64'd2);
    check("B overflow count", {61'd0, b_count}, 64'd4);
    check("B overflow busy", {63'd0, b_busy}, 64'd0);
    @(negedge clk);
    b_valid = 1'b1;
    b_data = 8'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("B byte refused after overflow", {63'd0, b_ready}, 64'd0);
    end
    b_valid = 1'b0;

    repeat (3) step();
    check("A scoreboard drained", 64'(q_a.size()), 64'd0);
    check("B scoreboard drained", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Writer side of the instruction path. It receives a byte stream from the debug/UART receiver and packs it, big-endian, into 32-bit MIPS instruction words. Each word is written into instruction memory at sequential addresses from 0. Loading ends on the HALT word. Optionally, each word's opcode is checked against the set the control unit decodes before the pipeline runs.

Parameters:
NBITS, 32, instruction word width; must be a multiple of BYTE_BITS
BYTE_BITS, 8, width of an incoming stream byte
ADDR_BITS, 8, instruction memory word-address width (depth 2^ADDR_BITS)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle pulse; begins a load from address 0
i_rx_data  in  BYTE_BITS  stream byte
i_rx_valid  in  1  i_rx_data valid
o_rx_ready  out  1  loader can accept a byte; a byte transfers when i_rx_valid && o_rx_ready
o_mem_addr  out  ADDR_BITS  instruction memory word address
o_mem_data  out  NBITS  instruction word to write
o_mem_we  out  1  one-cycle write strobe
o_busy  out  1  a load is in progress (RECV or WRITE)
o_done  out  1  load completed with HALT written
o_err_code  out  2  00 none, 01 illegal opcode, 10 memory overflow
o_count  out  ADDR_BITS+1  number of words written in the current load

Behaviour:
- Reset: the block enters IDLE. All outputs are 0; the byte index, word register and address are cleared. Reset applied in any state aborts the load immediately; no further writes occur.
- States:
  - IDLE
    - i_start -> RECV; address, o_count, byte index and o_err_code are cleared.
    - Bytes are not accepted (o_rx_ready=0).
  - RECV
    - o_rx_ready=1, o_busy=1.
    - The first accepted byte fills bits [NBITS-1 -: 8]; each following byte fills the next lower byte.
    - The byte index counts 0..NBITS/BYTE_BITS-1.
    - Accepting the last byte of a word -> WRITE.
    - i_start is ignored.
  - WRITE (exactly 1 cycle)
    - o_rx_ready=0.
    - o_mem_we=1, with o_mem_data = the assembled word and o_mem_addr = the current address. o_mem_we is registered and is 1 only in this cycle.
    - o_count increments.
    - Next state, in priority order:
      - word == 32'hFFFFFFFF (HALT) -> DONE
      - address == 2^ADDR_BITS-1 -> ERROR with code 10; the word is still written
      - otherwise the address increments -> RECV
  - DONE
    - o_done=1, o_busy=0; o_count holds its value.
    - i_start -> RECV, with o_done cleared in the same transition.
  - ERROR
    - o_err_code held, o_busy=0.
    - i_start -> RECV, with the code cleared.
- Latency: last byte of a word accepted on edge N -> o_mem_we high in cycle N+1 -> o_rx_ready high again in cycle N+2. Sustained throughput is one word per NBITS/BYTE_BITS+1 cycles.
- Address never wraps; overflow is always reported as ERROR.
- o_mem_addr/o_mem_data are stable in the write cycle and hold their values otherwise.
- i_rx_valid while o_rx_ready=0: the byte is not consumed; the upstream source holds it.

Optional Feature:
Macro OPCODE_CHECK_EN.
- Defined: in WRITE, a non-HALT word whose opcode bits [31:26] are not one of {000000 R-type, 100011 LW, 101011 SW, 000100 BEQ, 000010 J, 001000 ADDI, 001010 SLTI} is not written (o_mem_we=0). o_count is unchanged, and the state goes to ERROR with code 01. The HALT test takes priority over the opcode test.
- Undefined: no opcode checking; code 01 never occurs.

Decomposition:
- Shared package mips_pkg holds:
  - the opcode constants (R-type, LW, SW, BEQ, J, ADDI, SLTI) used by both this block and the control unit
  - the HALT word constant
  - the loader state enum (IDLE/RECV/WRITE/DONE/ERROR)
  - the error-code constants
- One sub-module is natural: byte_assembler. It contains the shift register and byte-index counter, and outputs word and word_valid.

Test Plan:
- Reset, i_start, bytes 20 01 00 05 then FF FF FF FF -> addr0=0x20010005 and addr1=0xFFFFFFFF written; o_done=1, o_count=2, o_err_code=00.
- Bytes 8C 22 00 04 with i_rx_valid gapped 3 cycles between bytes -> a single write of 0x8C220004 at addr0, with o_mem_we exactly one cycle after the 4th byte; o_rx_ready=0 during that write cycle.
- ADDR_BITS=2, four non-HALT words (0x20010001..0x20010004) -> four writes at addr 0..3, then ERROR with code 10 and o_count=4; the next byte is not accepted.
- OPCODE_CHECK_EN defined, word 0x3C010001 (opcode 001111) -> no write, ERROR with code 01; undefined -> written at addr0, no error.
- i_reset asserted after 2 of 4 bytes -> IDLE, all outputs 0; a subsequent i_start plus 20 01 00 05 writes 0x20010005 to addr0 with no residue from the aborted bytes.
- In DONE, i_start, then AC 22 00 08 -> o_done clears, o_count restarts, 0xAC220008 is written at addr0.
